// File: rtl/oser_pkg.sv
// oser_pkg: shared defaults, beat-count helpers and config check for output_serializer.
package oser_pkg;
  localparam int OSER_IN_W = 512;
  localparam int OSER_OUT_W = 64;
  function automatic int oser_beats(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
  function automatic bit oser_cfg_ok(input int in_w, input int out_w);
    return (in_w % out_w == 0) && (in_w / out_w >= 2);
  endfunction
  localparam int OSER_BEATS = oser_beats(OSER_IN_W, OSER_OUT_W);
  typedef logic [$clog2(OSER_BEATS)-1:0] beat_idx_t;
endpackage

// File: rtl/oser_word_fifo.sv
// oser_word_fifo: DEPTH-entry ring of full-width words; head is the oldest entry.
module oser_word_fifo #(
  parameter int W = 512,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? nxt(wr_q) : wr_q;
    rd_d = pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    head = mem_q[rd_q];
    occupancy = cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    mem_q <= mem_d;
endmodule

// File: rtl/output_serializer.sv
// output_serializer: buffers wide result words and emits them as OUT_W beats, gapless between words.
// Define OUTPUT_SERIALIZER_MSB_FIRST_EN to emit the most-significant slice first.
module output_serializer
  import oser_pkg::*;
#(
  parameter int IN_W = OSER_IN_W,
  parameter int OUT_W = OSER_OUT_W,
  parameter int DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_W-1:0]                   out_data,
  output logic                               out_last,
  output logic [$clog2(IN_W/OUT_W)-1:0]      beat_idx,
  output logic                               word_done,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy
);
  localparam int BEATS = oser_beats(IN_W, OUT_W);
  localparam int BW = $clog2(BEATS);
  localparam int CW = $clog2(DEPTH+1);
  if (!oser_cfg_ok(IN_W, OUT_W)) begin : g_bad_cfg
    $error("output_serializer: IN_W must be a multiple of OUT_W with at least 2 beats");
  end
  logic [IN_W-1:0] head;
  logic push, pop, fire, last, done_q, done_d;
  logic [BW-1:0] beat_q, beat_d;
  oser_word_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(in_data), .head(head), .occupancy(occupancy)
  );
  always_comb begin
    in_ready = occupancy < CW'(DEPTH);
    out_valid = occupancy != '0;
    push = in_valid && in_ready;
    last = beat_q == BW'(BEATS-1);
    fire = out_valid && out_ready;
    pop = fire && last;
    beat_d = fire ? (last ? '0 : beat_q + BW'(1)) : beat_q;
    done_d = pop;
    out_last = out_valid && last;
`ifdef OUTPUT_SERIALIZER_MSB_FIRST_EN
    out_data = out_valid ? head[IN_W-1-int'(beat_q)*OUT_W -: OUT_W] : '0;
`else
    out_data = out_valid ? head[int'(beat_q)*OUT_W +: OUT_W] : '0;
`endif
    beat_idx = beat_q;
    word_done = done_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      beat_q <= '0;
      done_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_output_serializer.sv
// tb_output_serializer: table-driven directed checks plus a mid-word reset sequence.
module tb_output_serializer;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [511:0] in_data = '0;
  logic in_ready, out_valid, out_last, word_done;
  logic [63:0] out_data;
  logic [2:0] beat_idx;
  logic [1:0] occupancy;
  int errors = 0, checks = 0;
  typedef struct {
    logic iv; logic [7:0] ib; logic orr;
    logic ov; logic [63:0] od; logic ol; logic [2:0] bi; logic wd; logic [1:0] occ; logic ir;
  } vec_t;
  vec_t q[$];
  output_serializer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .beat_idx(beat_idx), .word_done(word_done), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [511:0] mk(input logic [7:0] base);
    logic [511:0] w;
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = 64'(base) + 64'(k + 1);
    return w;
  endfunction
  function automatic logic [63:0] lane(input logic [7:0] base, input int b);
`ifdef OUTPUT_SERIALIZER_MSB_FIRST_EN
    return 64'(base) + 64'(8 - b);
`else
    return 64'(base) + 64'(b + 1);
`endif
  endfunction
  task automatic add(input bit iv, input logic [7:0] ib, input bit orr, input bit ov,
                     input logic [7:0] eb, input int b, input bit wd, input int occ, input bit ir);
    vec_t v;
    v.iv = iv; v.ib = ib; v.orr = orr; v.ov = ov;
    v.od = lane(eb, b); v.ol = ov && b == 7; v.bi = ov ? 3'(b) : 3'd0;
    v.wd = wd; v.occ = 2'(occ); v.ir = ir;
    q.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  initial begin
    add(1, 8'h00, 1, 0, 0, 0, 0, 0, 1);
    for (int b = 0; b < 8; b++) add(0, 0, 1, 1, 8'h00, b, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(1, 8'h10, 1, 0, 0, 0, 0, 0, 1);
    add(1, 8'h20, 1, 1, 8'h10, 0, 0, 1, 1);
    for (int b = 1; b < 8; b++) add(0, 0, 1, 1, 8'h10, b, 0, 2, 0);
    add(0, 0, 1, 1, 8'h20, 0, 1, 1, 1);
    for (int b = 1; b < 8; b++) add(0, 0, 1, 1, 8'h20, b, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(1, 8'h30, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h30, 0, 0, 1, 1);
    add(0, 0, 0, 1, 8'h30, 1, 0, 1, 1);
    add(0, 0, 0, 1, 8'h30, 1, 0, 1, 1);
    add(0, 0, 1, 1, 8'h30, 1, 0, 1, 1);
    for (int b = 2; b < 8; b++) add(0, 0, 1, 1, 8'h30, b, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(1, 8'h40, 1, 0, 0, 0, 0, 0, 1);
    add(1, 8'h50, 1, 1, 8'h40, 0, 0, 1, 1);
    for (int b = 1; b < 7; b++) add(0, 0, 1, 1, 8'h40, b, 0, 2, 0);
    add(1, 8'h60, 1, 1, 8'h40, 7, 0, 2, 0);
    add(1, 8'h60, 1, 1, 8'h50, 0, 1, 1, 1);
    for (int b = 1; b < 8; b++) add(0, 0, 1, 1, 8'h50, b, 0, 2, 0);
    add(0, 0, 1, 1, 8'h60, 0, 1, 1, 1);
    for (int b = 1; b < 8; b++) add(0, 0, 1, 1, 8'h60, b, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 1);
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset out_data", out_data, 0);
    chk("reset beat_idx", 64'(beat_idx), 0);
    chk("reset occupancy", 64'(occupancy), 0);
    reset = 0;
    foreach (q[i]) begin
      @(negedge clk);
      chk($sformatf("r%0d out_valid", i), 64'(out_valid), 64'(q[i].ov));
      if (q[i].ov) chk($sformatf("r%0d out_data", i), out_data, q[i].od);
      chk($sformatf("r%0d out_last", i), 64'(out_last), 64'(q[i].ol));
      chk($sformatf("r%0d beat_idx", i), 64'(beat_idx), 64'(q[i].bi));
      chk($sformatf("r%0d word_done", i), 64'(word_done), 64'(q[i].wd));
      chk($sformatf("r%0d occupancy", i), 64'(occupancy), 64'(q[i].occ));
      chk($sformatf("r%0d in_ready", i), 64'(in_ready), 64'(q[i].ir));
      in_valid = q[i].iv;
      in_data = mk(q[i].ib);
      out_ready = q[i].orr;
    end
    @(negedge clk);
    in_valid = 1;
    in_data = mk(8'h70);
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 10 && beat_idx != 3; i++) @(negedge clk);
    chk("rst beat3 reached", 64'(beat_idx), 3);
    chk("rst beat3 data", out_data, lane(8'h70, 3));
    reset = 1;
    in_valid = 1;
    in_data = mk(8'h90);
    #1;
    chk("rst async out_valid", 64'(out_valid), 0);
    chk("rst async occupancy", 64'(occupancy), 0);
    chk("rst async beat_idx", 64'(beat_idx), 0);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst no word_done %0d", i), 64'(word_done), 0);
      chk($sformatf("rst empty %0d", i), 64'(occupancy), 0);
    end
    in_valid = 1;
    in_data = mk(8'h80);
    @(negedge clk);
    in_valid = 0;
    chk("post-rst out_valid", 64'(out_valid), 1);
    chk("post-rst beat_idx", 64'(beat_idx), 0);
    chk("post-rst out_data", out_data, lane(8'h80, 0));
    chk("post-rst occupancy", 64'(occupancy), 1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("post-rst drained", 64'(occupancy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
